// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with optional grant hold limit
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   en        : enable; low releases any grant and blocks new ones
//   req[7:0]  : level-sensitive request lines
//   gnt[7:0]  : one-hot grant, zero when idle
//   gnt_idx   : current or last winner index
//   gnt_valid : a grant is active
module rr_arbiter8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  state_t     state_q, state_d;
  logic [2:0] cur_q, cur_d, win;
  logic [7:0] hold_q, hold_d;
  logic       found, others, at_limit;
  // Scan from cur+1 upward with wrap; cur itself is visited last, so a
  // pending competitor always beats the current owner.
  always_comb begin
    found = 1'b0;
    win   = cur_q;
    for (int k = 1; k <= 8; k++) begin
      if (!found && req[3'(cur_q + 3'(k))]) begin
        found = 1'b1;
        win   = 3'(cur_q + 3'(k));
      end
    end
  end
  assign others   = |(req & ~(8'b1 << cur_q));
  assign at_limit = (HOLD_MAX != 0) && (hold_q == HOLD_LAST);
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    hold_d  = hold_q;
    if (state_q == IDLE) begin
      if (en && |req) begin
        state_d = GRANT;
        cur_d   = win;
        hold_d  = 8'd0;
      end
    end else if (!en) begin
      state_d = IDLE;
    end else if (!req[cur_q]) begin
      state_d = others ? GRANT : IDLE;
      cur_d   = others ? win : cur_q;
      hold_d  = others ? 8'd0 : hold_q;
    end else if (at_limit) begin
      cur_d  = others ? win : cur_q;
      hold_d = 8'd0;
    end else begin
      hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= 3'd7;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      hold_q  <= hold_d;
    end
  end
  assign gnt       = (state_q == GRANT) ? (8'b1 << cur_q) : 8'd0;
  assign gnt_idx   = cur_q;
  assign gnt_valid = (state_q == GRANT);
endmodule
